tachyon_regfile_mp: RTL and testbench

- Parametrised multi-port register file for the Tachyon core; next generation of the 32x64, 3-read, 1-write file.
- Adds configurable depth, width and port counts, several write ports with fixed priority, and optional write-to-read bypass.
- Adds optional registered reads, optional hardwired-zero register 0, and a per-register busy scoreboard.
- Sits between the decode/issue stage (reads, busy allocation) and the writeback stage (writes).

---
 rtl/tachyon_regfile_mp_if.sv | 29 ++
 rtl/tachyon_regfile_mp.sv | 99 +++++++++
 tb/tb_tachyon_regfile_mp.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tachyon_regfile_mp_if.sv
// Bus bundle for the Tachyon multi-port register file: read ports, write ports and busy allocation.
// No valid/ready handshake: wr_enable and alloc_en are single-cycle strobes taken on the rising clk edge.
interface tachyon_regfile_mp_if #(
    parameter int SIZE        = 32,
    parameter int REG_WIDTH   = 64,
    parameter int NR_RD_PORTS = 3,
    parameter int NR_WR_PORTS = 2
);
    localparam int ADDR_WIDTH = $clog2(SIZE);

    logic [ADDR_WIDTH-1:0] rd_addr   [NR_RD_PORTS];
    logic [REG_WIDTH-1:0]  rd_val    [NR_RD_PORTS];
    logic                  rd_busy   [NR_RD_PORTS];
    logic                  wr_enable [NR_WR_PORTS];
    logic [ADDR_WIDTH-1:0] wr_addr   [NR_WR_PORTS];
    logic [REG_WIDTH-1:0]  wr_val    [NR_WR_PORTS];
    logic                  alloc_en;
    logic [ADDR_WIDTH-1:0] alloc_addr;

    modport master (
        output rd_addr, wr_enable, wr_addr, wr_val, alloc_en, alloc_addr,
        input  rd_val, rd_busy
    );

    modport slave (
        input  rd_addr, wr_enable, wr_addr, wr_val, alloc_en, alloc_addr,
        output rd_val, rd_busy
    );
endinterface

// File: rtl/tachyon_regfile_mp.sv
// Parametrised multi-port register file with fixed-priority writes, optional bypass,
// optional registered reads, optional hardwired-zero r0 and a per-register busy scoreboard.
module tachyon_regfile_mp #(
    parameter int SIZE        = 32,
    parameter int REG_WIDTH   = 64,
    parameter int NR_RD_PORTS = 3,
    parameter int NR_WR_PORTS = 2,
    parameter int RD_LATENCY  = 0,
    parameter int BYPASS      = 1,
    parameter int ZERO_REG0   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    tachyon_regfile_mp_if.slave  bus
);
    localparam int ADDR_WIDTH = $clog2(SIZE);

    logic [REG_WIDTH-1:0]   regs_q [SIZE];
    logic [REG_WIDTH-1:0]   regs_d [SIZE];
    logic [SIZE-1:0]        busy_q;
    logic [SIZE-1:0]        busy_d;
    logic [REG_WIDTH-1:0]   rd_val_d [NR_RD_PORTS];
    logic [NR_RD_PORTS-1:0] rd_busy_d;

    function automatic logic is_zero_reg(input logic [ADDR_WIDTH-1:0] a);
        return (ZERO_REG0 != 0) && (a == '0);
    endfunction

    // Ascending port loop gives the highest-index writer the last word; alloc is applied after writes so it wins.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        for (int k = 0; k < NR_WR_PORTS; k++) begin
            if (bus.wr_enable[k] && !is_zero_reg(bus.wr_addr[k])) begin
                regs_d[bus.wr_addr[k]] = bus.wr_val[k];
                busy_d[bus.wr_addr[k]] = 1'b0;
            end
        end
        if (bus.alloc_en && !is_zero_reg(bus.alloc_addr)) begin
            busy_d[bus.alloc_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q <= '{default: '0};
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    always_comb begin
        for (int j = 0; j < NR_RD_PORTS; j++) begin
            rd_val_d[j]  = regs_q[bus.rd_addr[j]];
            rd_busy_d[j] = busy_q[bus.rd_addr[j]];
            if (BYPASS != 0) begin
                for (int k = 0; k < NR_WR_PORTS; k++) begin
                    if (bus.wr_enable[k] && (bus.wr_addr[k] == bus.rd_addr[j])) begin
                        rd_val_d[j]  = bus.wr_val[k];
                        rd_busy_d[j] = bus.alloc_en && (bus.alloc_addr == bus.rd_addr[j]);
                    end
                end
            end
            if (is_zero_reg(bus.rd_addr[j])) begin
                rd_val_d[j]  = '0;
                rd_busy_d[j] = 1'b0;
            end
        end
    end

    generate
        if (RD_LATENCY == 1) begin : g_rd_reg
            logic [REG_WIDTH-1:0]   rd_val_q [NR_RD_PORTS];
            logic [NR_RD_PORTS-1:0] rd_busy_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    rd_val_q  <= '{default: '0};
                    rd_busy_q <= '0;
                end else begin
                    rd_val_q  <= rd_val_d;
                    rd_busy_q <= rd_busy_d;
                end
            end

            for (genvar j = 0; j < NR_RD_PORTS; j++) begin : g_out
                assign bus.rd_val[j]  = rd_val_q[j];
                assign bus.rd_busy[j] = rd_busy_q[j];
            end
        end else begin : g_rd_comb
            for (genvar j = 0; j < NR_RD_PORTS; j++) begin : g_out
                assign bus.rd_val[j]  = rd_val_d[j];
                assign bus.rd_busy[j] = rd_busy_d[j];
            end
        end
    endgenerate
endmodule

// File: tb/tb_tachyon_regfile_mp.sv
// Bench for tachyon_regfile_mp: one instance with defaults (comb read, bypass, zero r0) and one with
// registered read, no bypass, writable r0, both checked every cycle against an array-level model.
module tb_tachyon_regfile_mp;
    localparam int SIZE = 32;
    localparam int W    = 64;
    localparam int NR   = 3;
    localparam int NW   = 2;
    localparam int AW   = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tachyon_regfile_mp_if #(.SIZE(SIZE), .REG_WIDTH(W), .NR_RD_PORTS(NR), .NR_WR_PORTS(NW)) bus0 ();
    tachyon_regfile_mp_if #(.SIZE(SIZE), .REG_WIDTH(W), .NR_RD_PORTS(NR), .NR_WR_PORTS(NW)) bus1 ();

    tachyon_regfile_mp #(
        .SIZE(SIZE), .REG_WIDTH(W), .NR_RD_PORTS(NR), .NR_WR_PORTS(NW),
        .RD_LATENCY(0), .BYPASS(1), .ZERO_REG0(1)
    ) dut0 (.clk(clk), .rst(rst), .bus(bus0));

    tachyon_regfile_mp #(
        .SIZE(SIZE), .REG_WIDTH(W), .NR_RD_PORTS(NR), .NR_WR_PORTS(NW),
        .RD_LATENCY(1), .BYPASS(0), .ZERO_REG0(0)
    ) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    // Stimulus
    logic [AW-1:0] rd_addr [NR];
    logic          wr_en   [NW];
    logic [AW-1:0] wr_addr [NW];
    logic [W-1:0]  wr_val  [NW];
    logic          alloc_en;
    logic [AW-1:0] alloc_addr;

    // Reference model: architectural register contents and busy bits per configuration
    logic [W-1:0] m0_regs [SIZE];
    logic         m0_busy [SIZE];
    logic [W-1:0] m1_regs [SIZE];
    logic         m1_busy [SIZE];
    logic [W-1:0] exp1_val  [NR];
    logic         exp1_busy [NR];
    logic         started = 1'b0;

    int checks = 0;
    int errors = 0;

    task automatic apply();
        for (int j = 0; j < NR; j++) begin
            bus0.rd_addr[j] = rd_addr[j];
            bus1.rd_addr[j] = rd_addr[j];
        end
        for (int k = 0; k < NW; k++) begin
            bus0.wr_enable[k] = wr_en[k];   bus1.wr_enable[k] = wr_en[k];
            bus0.wr_addr[k]   = wr_addr[k]; bus1.wr_addr[k]   = wr_addr[k];
            bus0.wr_val[k]    = wr_val[k];  bus1.wr_val[k]    = wr_val[k];
        end
        bus0.alloc_en = alloc_en;     bus1.alloc_en = alloc_en;
        bus0.alloc_addr = alloc_addr; bus1.alloc_addr = alloc_addr;
    endtask

    task automatic idle_inputs();
        for (int k = 0; k < NW; k++) begin
            wr_en[k] = 1'b0; wr_addr[k] = '0; wr_val[k] = '0;
        end
        alloc_en = 1'b0;
        alloc_addr = '0;
    endtask

    task automatic set_reads(input int a0, input int a1, input int a2);
        rd_addr[0] = AW'(a0);
        rd_addr[1] = AW'(a1);
        rd_addr[2] = AW'(a2);
    endtask

    // What a combinational, bypassing, zero-r0 read must return right now
    function automatic void exp_read0(input int a, output logic [W-1:0] v, output logic b);
        v = m0_regs[a];
        b = m0_busy[a];
        for (int k = 0; k < NW; k++) begin
            if (wr_en[k] && int'(wr_addr[k]) == a) begin
                v = wr_val[k];
                b = alloc_en && (int'(alloc_addr) == a);
            end
        end
        if (a == 0) begin
            v = '0;
            b = 1'b0;
        end
    endfunction

    task automatic check_all();
        logic [W-1:0] v;
        logic         b;
        if (!started) return;
        for (int j = 0; j < NR; j++) begin
            exp_read0(int'(rd_addr[j]), v, b);
            checks++;
            if (bus0.rd_val[j] !== v) begin
                errors++;
                $display("FAIL dut0_val port%0d addr%0d: got %h expected %h", j, rd_addr[j], bus0.rd_val[j], v);
            end
            checks++;
            if (bus0.rd_busy[j] !== b) begin
                errors++;
                $display("FAIL dut0_busy port%0d addr%0d: got %b expected %b", j, rd_addr[j], bus0.rd_busy[j], b);
            end
            checks++;
            if (bus1.rd_val[j] !== exp1_val[j]) begin
                errors++;
                $display("FAIL dut1_val port%0d: got %h expected %h", j, bus1.rd_val[j], exp1_val[j]);
            end
            checks++;
            if (bus1.rd_busy[j] !== exp1_busy[j]) begin
                errors++;
                $display("FAIL dut1_busy port%0d: got %b expected %b", j, bus1.rd_busy[j], exp1_busy[j]);
            end
        end
    endtask

    // Architectural effect of one rising edge with the current inputs
    task automatic model_edge();
        if (rst) begin
            for (int i = 0; i < SIZE; i++) begin
                m0_regs[i] = '0; m0_busy[i] = 1'b0;
                m1_regs[i] = '0; m1_busy[i] = 1'b0;
            end
            for (int j = 0; j < NR; j++) begin
                exp1_val[j] = '0; exp1_busy[j] = 1'b0;
            end
            started = 1'b1;
            return;
        end
        for (int j = 0; j < NR; j++) begin
            exp1_val[j]  = m1_regs[rd_addr[j]];
            exp1_busy[j] = m1_busy[rd_addr[j]];
        end
        for (int k = 0; k < NW; k++) begin
            if (wr_en[k]) begin
                if (wr_addr[k] != 0) begin
                    m0_regs[wr_addr[k]] = wr_val[k];
                    m0_busy[wr_addr[k]] = 1'b0;
                end
                m1_regs[wr_addr[k]] = wr_val[k];
                m1_busy[wr_addr[k]] = 1'b0;
            end
        end
        if (alloc_en) begin
            if (alloc_addr != 0) m0_busy[alloc_addr] = 1'b1;
            m1_busy[alloc_addr] = 1'b1;
        end
    endtask

    task automatic settle();
        apply();
        #3;
        check_all();
    endtask

    task automatic advance();
        model_edge();
        @(negedge clk);
    endtask

    task automatic lit(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic random_inputs();
        int lim;
        lim = ($urandom_range(0, 1) == 0) ? 7 : SIZE - 1;
        for (int j = 0; j < NR; j++) rd_addr[j] = AW'($urandom_range(0, lim));
        for (int k = 0; k < NW; k++) begin
            wr_en[k]   = ($urandom_range(0, 2) != 0);
            wr_addr[k] = AW'($urandom_range(0, lim));
            wr_val[k]  = {$urandom(), $urandom()};
        end
        alloc_en   = ($urandom_range(0, 2) == 0);
        alloc_addr = AW'($urandom_range(0, lim));
        rst        = ($urandom_range(0, 199) == 0);
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        set_reads(0, 0, 0);
        apply();
        @(negedge clk);

        // Reset with writes and an allocation pending
        wr_en[0] = 1'b1; wr_addr[0] = AW'(1); wr_val[0] = 64'h1;
        wr_en[1] = 1'b1; wr_addr[1] = AW'(2); wr_val[1] = 64'h2;
        alloc_en = 1'b1; alloc_addr = AW'(6);
        settle(); advance();
        rst = 1'b0;
        idle_inputs();

        // Reset state sweep on all ports
        for (int i = 0; i < SIZE; i++) begin
            set_reads(i, i, i);
            settle();
            advance();
        end
        settle();
        lit("reset_r31_dut1", bus1.rd_val[0], 64'h0);
        advance();

        // Two ports, two registers, same cycle
        wr_en[0] = 1'b1; wr_addr[0] = AW'(5); wr_val[0] = 64'hDEAD_BEEF_0000_0005;
        wr_en[1] = 1'b1; wr_addr[1] = AW'(9); wr_val[1] = 64'h1111;
        set_reads(5, 9, 0);
        settle(); advance();
        idle_inputs();
        settle();
        lit("r5_dut0", bus0.rd_val[0], 64'hDEAD_BEEF_0000_0005);
        lit("r9_dut0", bus0.rd_val[1], 64'h1111);
        lit("r0_dut0", bus0.rd_val[2], 64'h0);
        advance();
        settle();
        lit("r5_dut1", bus1.rd_val[0], 64'hDEAD_BEEF_0000_0005);
        lit("r9_dut1", bus1.rd_val[1], 64'h1111);
        advance();

        // Same-address write conflict: highest port wins
        wr_en[0] = 1'b1; wr_addr[0] = AW'(7); wr_val[0] = 64'hAA;
        wr_en[1] = 1'b1; wr_addr[1] = AW'(7); wr_val[1] = 64'hBB;
        set_reads(7, 7, 7);
        settle();
        lit("r7_bypass_dut0", bus0.rd_val[0], 64'hBB);
        advance();
        idle_inputs();
        settle();
        lit("r7_old_dut1", bus1.rd_val[0], 64'h0);
        lit("r7_dut0", bus0.rd_val[1], 64'hBB);
        advance();
        settle();
        lit("r7_new_dut1", bus1.rd_val[0], 64'hBB);
        advance();

        // Busy scoreboard on r3
        alloc_en = 1'b1; alloc_addr = AW'(3);
        set_reads(3, 3, 3);
        settle();
        lit("r3_busy_before", 64'(bus0.rd_busy[0]), 64'h0);
        advance();
        idle_inputs();
        settle();
        lit("r3_busy_alloc", 64'(bus0.rd_busy[0]), 64'h1);
        advance();
        wr_en[0] = 1'b1; wr_addr[0] = AW'(3); wr_val[0] = 64'h33;
        settle();
        lit("r3_busy_bypass_wr", 64'(bus0.rd_busy[0]), 64'h0);
        advance();
        idle_inputs();
        settle();
        lit("r3_busy_cleared", 64'(bus0.rd_busy[0]), 64'h0);
        advance();
        wr_en[1] = 1'b1; wr_addr[1] = AW'(3); wr_val[1] = 64'h44;
        alloc_en = 1'b1; alloc_addr = AW'(3);
        settle();
        lit("r3_busy_bypass_alloc", 64'(bus0.rd_busy[0]), 64'h1);
        lit("r3_val_bypass_alloc", bus0.rd_val[0], 64'h44);
        advance();
        idle_inputs();
        settle();
        lit("r3_busy_alloc_wins", 64'(bus0.rd_busy[0]), 64'h1);
        lit("r3_val_after", bus0.rd_val[0], 64'h44);
        advance();

        // Writes and allocation to r0
        wr_en[1] = 1'b1; wr_addr[1] = AW'(0); wr_val[1] = 64'hFFFF;
        alloc_en = 1'b1; alloc_addr = AW'(0);
        set_reads(0, 0, 0);
        settle();
        lit("r0_val_same", bus0.rd_val[0], 64'h0);
        lit("r0_busy_same", 64'(bus0.rd_busy[0]), 64'h0);
        advance();
        idle_inputs();
        settle();
        lit("r0_val_after", bus0.rd_val[0], 64'h0);
        lit("r0_busy_after", 64'(bus0.rd_busy[0]), 64'h0);
        advance();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            random_inputs();
            settle();
            advance();
        end
        rst = 1'b0;

        // Reset while writes to r1..r4 and alloc r6 are active
        for (int i = 1; i <= 4; i++) begin
            wr_en[0] = 1'b1; wr_addr[0] = AW'(i); wr_val[0] = 64'h100 + 64'(i);
            wr_en[1] = 1'b1; wr_addr[1] = AW'(i); wr_val[1] = 64'h200 + 64'(i);
            alloc_en = 1'b1; alloc_addr = AW'(6);
            settle(); advance();
        end
        for (int k = 0; k < NW; k++) begin
            wr_en[k] = 1'b1; wr_addr[k] = AW'(k + 1); wr_val[k] = 64'hCAFE;
        end
        alloc_en = 1'b1; alloc_addr = AW'(6);
        rst = 1'b1;
        settle(); advance();
        rst = 1'b0;
        idle_inputs();
        set_reads(1, 4, 6);
        settle();
        lit("rst_r1_dut0", bus0.rd_val[0], 64'h0);
        lit("rst_r4_dut0", bus0.rd_val[1], 64'h0);
        lit("rst_r6_busy_dut0", 64'(bus0.rd_busy[2]), 64'h0);
        lit("rst_regout_val_dut1", bus1.rd_val[0], 64'h0);
        lit("rst_regout_busy_dut1", 64'(bus1.rd_busy[2]), 64'h0);
        advance();
        settle();
        lit("rst_r4_dut1", bus1.rd_val[1], 64'h0);
        lit("rst_r6_busy_dut1", 64'(bus1.rd_busy[2]), 64'h0);
        advance();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
